// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for DIGITS common-select
// 7-segment digits sharing one external hex-to-segment decoder.
// Segment and select outputs are registered and lag the scan state by one cycle.
module seg_scan_ctrl #(
  parameter int DIGITS    = 8,
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 2
) (
  input  logic                  clkI,
  input  logic                  rstnI,
  input  logic [4*DIGITS-1:0]   valueI,
  input  logic                  loadI,
  input  logic [DIGITS-1:0]     dpI,
  input  logic [DIGITS-1:0]     blankI,
  input  logic                  lzsI,
  output logic [3:0]            numO,
  input  logic [0:7]            segI,
  output logic [0:7]            segO,
  output logic [DIGITS-1:0]     selO
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = $clog2(CLK_DIV);

  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] val_q, val_d;
  logic [DIGITS-1:0]   dp_q, dp_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic [0:7]          seg_q, seg_d;
  logic [DIGITS-1:0]   sel_q, sel_d;

  logic [DIGITS-1:0]   zero_from;
  logic                kill;

  // The decoder's own dp bit is replaced by the shadowed per-digit dp.
  logic unused_dec_dp;
  assign unused_dec_dp = segI[7];

  // Nibble of the currently scanned digit, sent to the shared decoder.
  assign numO = val_q[4*idx_q +: 4];

  // zero_from[k]: shadow nibbles k..DIGITS-1 are all zero (scanned from the top).
  always_comb begin
    logic        acc;
    int unsigned k;
    zero_from = '0;
    acc       = 1'b1;
    k         = 0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      k            = DIGITS - 1 - i;
      acc          = acc & (val_q[4*k +: 4] == 4'h0);
      zero_from[k] = acc;
    end
  end

  // Segments are dark during dead time, for blanked digits and for suppressed leading zeros.
  always_comb begin
    kill = (cnt_q < BLANK_END) || blank_q[idx_q] ||
           (lzsI && (idx_q != '0) && zero_from[idx_q]);
  end

  // Next-state for prescaler, digit index, shadow registers and output stage.
  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    val_d   = val_q;
    dp_d    = dp_q;
    blank_d = blank_q;
    sel_d   = '0;
    seg_d   = '0;

    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    if (loadI) begin
      val_d   = valueI;
      dp_d    = dpI;
      blank_d = blankI;
    end

    sel_d[idx_q] = 1'b1;
    if (!kill) begin
      seg_d = {segI[0:6], dp_q[idx_q]};
    end
  end

  // State registers; reset clears everything asynchronously.
  always_ff @(posedge clkI or negedge rstnI) begin
    if (!rstnI) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      val_q   <= '0;
      dp_q    <= '0;
      blank_q <= '0;
      seg_q   <= '0;
      sel_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      val_q   <= val_d;
      dp_q    <= dp_d;
      blank_q <= blank_d;
      seg_q   <= seg_d;
      sel_q   <= sel_d;
    end
  end

  assign segO = seg_q;
  assign selO = sel_q;

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a bank of common-select 7-segment digits.
- Shares one hex-to-segment decoder across DIGITS digits.
- Per digit: presents the current nibble to the decoder, registers the returned pattern, drives the digit select, and applies per-digit blanking, decimal points, leading-zero suppression and anti-ghosting dead time.
- Sits between the register/value source and the board display pins.

Parameters:
- DIGITS, 8, number of multiplexed digits (1..16).
- CLK_DIV, 50000, clock cycles each digit is selected (>= 2).
- BLANK_CYC, 2, dead cycles at the start of each digit slot during which segments are forced off (< CLK_DIV).

Ports:
- clkI, input, 1, system clock; all state updates on the rising edge.
- rstnI, input, 1, asynchronous active-low reset.
- valueI, input, 4*DIGITS, hex value. Nibble k (bits 4k+3:4k) maps to digit k; digit 0 is least significant.
- loadI, input, 1, capture valueI/dpI/blankI into the shadow registers.
- dpI, input, DIGITS, decimal point per digit (1 = lit).
- blankI, input, DIGITS, force digit k dark (1 = blank).
- lzsI, input, 1, leading-zero suppression enable. Sampled live, not shadowed.
- numO, output, 4, nibble to the shared decoder. Combinational from the shadow register and digit index.
- segI, input, 8, decoder result [0:7] = a..g,dp. Decoder is combinational, same cycle as numO; its dp bit is ignored.
- segO, output, 8, registered segment drive [0:7] = a..g,dp; 1 = lit.
- selO, output, DIGITS, registered one-hot digit select; 1 = selected.

Behaviour:
- Reset (async, rstnI=0): idx=0, cnt=0, shadow value/dp/blank=0, segO=0, selO=0. Release is synchronous to the first clkI edge after rstnI=1. Reset asserted mid-scan clears everything immediately; no partial state survives.
- Prescaler cnt counts 0..CLK_DIV-1 and wraps to 0.
  - When cnt==CLK_DIV-1: idx advances, idx = (idx==DIGITS-1) ? 0 : idx+1.
  - DIGITS=1: idx stays 0.
- Shadow registers:
  - loadI=1 at an edge captures valueI, dpI and blankI.
  - The new value is used from the next cycle; there is no wait for a slot boundary.
  - loadI held high reloads every cycle.
- numO = shadow nibble[idx].
- Output stage registers, every edge:
  - selO <= one-hot(idx).
  - segO <= kill ? 0 : {segI[0:6], shadow_dp[idx]}.
- Latency: segO/selO lag idx/cnt by exactly 1 cycle, and the two stay mutually aligned.
- kill = (cnt < BLANK_CYC) OR shadow_blank[idx] OR lz[idx].
- Leading-zero suppression, lz[k]:
  - lz[k] = 1 when lzsI=1, k != 0, and shadow nibbles k..DIGITS-1 are all 0.
  - Digit 0 is never suppressed, so value 0 shows a single "0".
  - Suppressed digits also drop their dp.
- selO is never 0 after the first post-reset edge. During dead time the digit is selected but segO=0.
- Simultaneous loadI and slot wrap: idx advances and the shadow updates on the same edge. The next slot shows the new value.

Test Plan (DIGITS=4, CLK_DIV=4, BLANK_CYC=1, decoder model attached):
- Reset then loadI pulse with valueI=16'h1234, dpI=0, blankI=0, lzsI=0:
  - selO cycles 0001,0010,0100,1000, each for 4 cycles.
  - In each slot, segO is 0 for 1 cycle, then 8'b0110_0110 / 1111_0010 / 1101_1010 / 0110_0000 for digits 0..3 (nibbles 4,3,2,1).
- valueI=16'h0070, lzsI=1:
  - Digits 3 and 2 stay dark; digit 1 shows 1110_0000; digit 0 shows 1111_1100.
  - Same value with lzsI=0: digits 3 and 2 show 1111_1100.
- valueI=16'h0000, lzsI=1, dpI=4'b1111: digit 0 shows 1111_1101; digits 1..3 dark (dp suppressed).
- blankI=4'b0100, dpI=4'b0001, valueI=16'hABCD: digit 2 dark throughout its slot; digit 0 shows 0111_1011; other digits decode normally.
- Load mid-slot: loadI at cnt==2 of digit 1's slot, changing the nibble 3 -> 5. segO becomes 1011_0110 two edges later, still within the same slot.
- Async reset mid-scan: drop rstnI between edges while idx=2. segO and selO go to 0 immediately. After release, the scan restarts at digit 0 with the shadow cleared: digit 0 shows 1111_1100 with lzsI=0.
